// File: rtl/i2s_rx.sv
// I2S receiver: syncs SCK/WS/SD into clk_in, deserializes MSB-first L/R words, emits pairs on valid/ready.
// Pair valid 1 clk after the SCK rise that captures the right LSB; an unaccepted pair is overwritten with overflow_out.
module i2s_rx #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             sck_in,
   input  logic             ws_in,
   input  logic             sd_in,
   output logic [WIDTH-1:0] output_l_tdata,
   output logic [WIDTH-1:0] output_r_tdata,
   output logic             output_tvalid,
   input  logic             output_tready,
   output logic             overflow_out,
   output logic             short_word_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] WMAX = CW'(WIDTH);

   typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

   state_t           state_q, state_d;
   logic [2:0]       sck_q;
   logic [1:0]       ws_q, sd_q;
   logic             ws_p1_q, ws_p1_d, ws_p2_q, ws_p2_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             chan_q, chan_d;
   logic             left_ok_q, left_ok_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] l_q, l_d, r_q, r_d;
   logic             vld_q, vld_d, ovf_q, ovf_d, short_q, short_d;

   logic             sck_rise, ws_s, sd_s;
   logic [WIDTH-1:0] word;
   logic             word_done, pair_done;

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign ws_s     = ws_q[1];
   assign sd_s     = sd_q[1];
   assign word     = {shift_q[WIDTH-2:0], sd_s};

   always_comb begin
      state_d     = state_q;
      ws_p1_d     = ws_p1_q;
      ws_p2_d     = ws_p2_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      chan_d      = chan_q;
      left_ok_d   = left_ok_q;
      left_hold_d = left_hold_q;
      short_d     = 1'b0;
      word_done   = 1'b0;
      pair_done   = 1'b0;
      if (sck_rise) begin
         ws_p1_d = ws_s;
         ws_p2_d = ws_p1_q;
         case (state_q)
            PRIME0: state_d = PRIME1;
            PRIME1: state_d = RUN;
            RUN: begin
               // WS changed one rise ago: this bit is the MSB of a new word (I2S one-bit delay)
               if (ws_p1_q != ws_p2_q) begin
                  if (bit_cnt_q < WMAX) begin
                     short_d   = 1'b1;
                     left_ok_d = 1'b0;
                  end
                  shift_d   = {{(WIDTH-1){1'b0}}, sd_s};
                  bit_cnt_d = CW'(1);
                  chan_d    = ws_p1_q;
               end else if (bit_cnt_q < WMAX) begin
                  shift_d   = word;
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  word_done = (bit_cnt_q == WMAX - CW'(1));
               end
               if (word_done) begin
                  if (!chan_q) begin
                     left_hold_d = word;
                     left_ok_d   = 1'b1;
                  end else if (left_ok_q) begin
                     pair_done = 1'b1;
                     left_ok_d = 1'b0;
                  end
               end
            end
            default: state_d = PRIME0;
         endcase
      end
   end

   always_comb begin
      l_d   = l_q;
      r_d   = r_q;
      vld_d = vld_q;
      ovf_d = 1'b0;
      if (pair_done) begin
         l_d   = left_hold_q;
         r_d   = word;
         vld_d = 1'b1;
         ovf_d = vld_q & ~output_tready;
      end else if (vld_q && output_tready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= PRIME0;
         sck_q       <= '0;
         ws_q        <= '0;
         sd_q        <= '0;
         ws_p1_q     <= 1'b0;
         ws_p2_q     <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= WMAX;
         chan_q      <= 1'b0;
         left_ok_q   <= 1'b0;
         left_hold_q <= '0;
         l_q         <= '0;
         r_q         <= '0;
         vld_q       <= 1'b0;
         ovf_q       <= 1'b0;
         short_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_q       <= {sck_q[1:0], sck_in};
         ws_q        <= {ws_q[0], ws_in};
         sd_q        <= {sd_q[0], sd_in};
         ws_p1_q     <= ws_p1_d;
         ws_p2_q     <= ws_p2_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         chan_q      <= chan_d;
         left_ok_q   <= left_ok_d;
         left_hold_q <= left_hold_d;
         l_q         <= l_d;
         r_q         <= r_d;
         vld_q       <= vld_d;
         ovf_q       <= ovf_d;
         short_q     <= short_d;
      end
   end

   assign output_l_tdata = l_q;
   assign output_r_tdata = r_q;
   assign output_tvalid  = vld_q;
   assign overflow_out   = ovf_q;
   assign short_word_out = short_q;

endmodule
